// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that shares one clocked S-R latch (a status flag) between
// N_REQ requesters, sequencing set/clear pulses and checking the Q/Q' feedback.
module sr_flag_arbiter #(
   parameter int N_REQ      = 4,
   parameter int PULSE_LEN  = 2,
   parameter int SETTLE_LEN = 1
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [N_REQ-1:0]         i_req_valid,
   input  logic [N_REQ-1:0]         i_req_op,
   output logic [N_REQ-1:0]         o_req_ready,
   output logic                     o_s_out,
   output logic                     o_r_out,
   output logic                     o_en_out,
   input  logic                     i_q_in,
   input  logic                     i_q_prim_in,
   output logic [$clog2(N_REQ)-1:0] o_grant_id,
   output logic                     o_busy,
   output logic                     o_err,
   output logic [1:0]               o_state
);

   localparam int GW   = $clog2(N_REQ);
   localparam int MAXL = (PULSE_LEN > SETTLE_LEN) ? PULSE_LEN : SETTLE_LEN;
   localparam int CW   = $clog2(MAXL + 1);

   // Handshake: a requester holds valid/op until it sees its one-cycle ready
   // pulse; op is sampled only at the grant edge, and a valid dropped after the
   // grant still completes with a ready pulse.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SETTLE = 2'd2,
      ST_ACK    = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [CW-1:0]    w_cnt_nxt;
   logic [GW-1:0]    r_grant;
   logic [GW-1:0]    w_grant_nxt;
   logic [GW-1:0]    r_rr;
   logic [GW-1:0]    w_rr_nxt;
   logic [GW-1:0]    w_idx;
   logic [GW-1:0]    w_pick;
   logic             w_found;
   logic             r_op;
   logic             w_op_nxt;
   logic             r_err;
   logic             w_err_nxt;
   logic             w_fb_bad;
   logic             r_s;
   logic             r_r;
   logic             r_en;
   logic             r_busy;
   logic [N_REQ-1:0] r_ready;
   logic [N_REQ-1:0] w_ready_nxt;

   // First valid requester at or after the round-robin pointer, with wrap.
   always_comb begin
      w_found = 1'b0;
      w_pick  = r_rr;
      w_idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_idx = GW'((int'(r_rr) + i) % N_REQ);
         if (!w_found && i_req_valid[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
         end
      end
   end

   // Latch must read back the written value with complementary outputs.
   assign w_fb_bad = (i_q_in != r_op) || (i_q_in == i_q_prim_in);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_grant_nxt = r_grant;
      w_op_nxt    = r_op;
      w_rr_nxt    = r_rr;
      w_err_nxt   = r_err;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_grant_nxt = w_pick;
               w_op_nxt    = i_req_op[w_pick];
               w_cnt_nxt   = '0;
               w_state_nxt = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            if (int'(r_cnt) == PULSE_LEN - 1) begin
               w_cnt_nxt   = '0;
               w_state_nxt = (SETTLE_LEN == 0) ? ST_ACK : ST_SETTLE;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         ST_SETTLE: begin
            if (int'(r_cnt) == SETTLE_LEN - 1) begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_ACK;
            end else begin
               w_cnt_nxt = r_cnt + CW'(1);
            end
         end
         ST_ACK: begin
            w_err_nxt   = r_err | w_fb_bad;
            w_rr_nxt    = (r_grant == GW'(N_REQ - 1)) ? '0 : r_grant + GW'(1);
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      w_ready_nxt = '0;
      if (w_state_nxt == ST_ACK) begin
         w_ready_nxt[w_grant_nxt] = 1'b1;
      end
   end

   // Outputs are registered from the next state so they line up with r_state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_grant <= '0;
         r_rr    <= '0;
         r_op    <= 1'b0;
         r_err   <= 1'b0;
         r_s     <= 1'b0;
         r_r     <= 1'b0;
         r_en    <= 1'b0;
         r_busy  <= 1'b0;
         r_ready <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_grant <= w_grant_nxt;
         r_rr    <= w_rr_nxt;
         r_op    <= w_op_nxt;
         r_err   <= w_err_nxt;
         r_s     <= (w_state_nxt == ST_DRIVE) && w_op_nxt;
         r_r     <= (w_state_nxt == ST_DRIVE) && !w_op_nxt;
         r_en    <= (w_state_nxt == ST_DRIVE);
         r_busy  <= (w_state_nxt != ST_IDLE);
         r_ready <= w_ready_nxt;
      end
   end

   assign o_req_ready = r_ready;
   assign o_s_out     = r_s;
   assign o_r_out     = r_r;
   assign o_en_out    = r_en;
   assign o_grant_id  = r_grant;
   assign o_busy      = r_busy;
   assign o_err       = r_err;
   assign o_state     = r_state;

endmodule
